// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider.
// Provides the FSM state encoding and the default operand width.
package div_pkg;

   localparam int DIV_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_ITER   = 2'd2,
      S_FINISH = 2'd3
   } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Switch-driven Run handshake and result bus of the divider.
// master: Run/Dividend/Divisor out; slave: Quotient/Remainder/Busy/Done/DivByZero out.
interface seq_divider_if
   import div_pkg::*;
   #(parameter int WIDTH = DIV_WIDTH);

   logic             Run;
   logic [WIDTH-1:0] Dividend;
   logic [WIDTH-1:0] Divisor;
   logic [WIDTH-1:0] Quotient;
   logic [WIDTH-1:0] Remainder;
   logic             Busy;
   logic             Done;
   logic             DivByZero;

   modport master (
      output Run, Dividend, Divisor,
      input  Quotient, Remainder, Busy, Done, DivByZero
   );

   modport slave (
      input  Run, Dividend, Divisor,
      output Quotient, Remainder, Busy, Done, DivByZero
   );

endinterface

// File: rtl/div_datapath.sv
// A/Q/B/count registers, shift-subtract step and published result registers.
// Ports: Clk, Reset, load/step/publish strobes in; results, last_iter, div_zero out.
module div_datapath
   import div_pkg::*;
   #(parameter int WIDTH = DIV_WIDTH)
   (
      input  logic             Clk,
      input  logic             Reset,
      input  logic             load,
      input  logic             step,
      input  logic             publish,
      input  logic [WIDTH-1:0] Dividend,
      input  logic [WIDTH-1:0] Divisor,
      output logic [WIDTH-1:0] Quotient,
      output logic [WIDTH-1:0] Remainder,
      output logic             DivByZero,
      output logic             last_iter,
      output logic             div_zero
   );

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH:0]     a;
   logic [WIDTH-1:0]   q;
   logic [WIDTH-1:0]   b;
   logic [CW-1:0]      count;

   logic [2*WIDTH:0]   sh;
   logic [WIDTH:0]     a_sh;
   logic [WIDTH-1:0]   q_sh;
   logic [WIDTH+1:0]   diff;
   logic [WIDTH:0]     a_nxt;
   logic [WIDTH-1:0]   q_nxt;

   assign div_zero  = (Divisor == '0);
   assign last_iter = (count == CW'(WIDTH - 1));

   assign sh   = {a, q} << 1;
   assign a_sh = sh[2*WIDTH:WIDTH];
   assign q_sh = sh[WIDTH-1:0];
   // Extra top bit exposes the borrow; it alone decides restore vs keep.
   assign diff = {1'b0, a_sh} - {2'b00, b};

   always_comb begin
      a_nxt = a_sh;
      q_nxt = q_sh;
      if (!diff[WIDTH+1]) begin
         a_nxt = diff[WIDTH:0];
         q_nxt = {q_sh[WIDTH-1:1], 1'b1};
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         a         <= '0;
         q         <= '0;
         b         <= '0;
         count     <= '0;
         Quotient  <= '0;
         Remainder <= '0;
         DivByZero <= 1'b0;
      end else begin
         if (load) begin
            a     <= '0;
            q     <= Dividend;
            b     <= Divisor;
            count <= '0;
         end else if (step) begin
            a     <= a_nxt;
            q     <= q_nxt;
            count <= count + 1'b1;
         end
         if (publish) begin
            if (load) begin
               Quotient  <= '1;
               Remainder <= Dividend;
               DivByZero <= 1'b1;
            end else begin
               // Publish the values being written this cycle.
               Quotient  <= q_nxt;
               Remainder <= a_nxt[WIDTH-1:0];
               DivByZero <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Unsigned sequential restoring divider: Moore FSM around div_datapath.
// Ports: Clk, Reset, bus (slave: Run/Dividend/Divisor in, results/Busy/Done out).
module seq_divider
   import div_pkg::*;
   #(parameter int WIDTH = DIV_WIDTH)
   (
      input  logic          Clk,
      input  logic          Reset,
      seq_divider_if.slave  bus
   );

   state_t state;
   logic   busy_q;
   logic   done_q;
   logic   load;
   logic   step;
   logic   publish;
   logic   last_iter;
   logic   div_zero;

   assign load    = (state == S_LOAD);
   assign step    = (state == S_ITER);
   assign publish = (load & div_zero) | (step & last_iter);

   assign bus.Busy = busy_q;
   assign bus.Done = done_q;

   // Busy/Done are registered alongside the state so they track it exactly.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state  <= S_IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.Run) begin
                  state  <= S_LOAD;
                  busy_q <= 1'b1;
               end
            end
            S_LOAD: begin
               if (div_zero) begin
                  state  <= S_FINISH;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else begin
                  state  <= S_ITER;
               end
            end
            S_ITER: begin
               if (last_iter) begin
                  state  <= S_FINISH;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            S_FINISH: begin
               // Held Run keeps the result up; no auto-restart.
               if (!bus.Run) begin
                  state  <= S_IDLE;
                  done_q <= 1'b0;
               end
            end
            default: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   div_datapath #(.WIDTH(WIDTH)) u_dp (
      .Clk       (Clk),
      .Reset     (Reset),
      .load      (load),
      .step      (step),
      .publish   (publish),
      .Dividend  (bus.Dividend),
      .Divisor   (bus.Divisor),
      .Quotient  (bus.Quotient),
      .Remainder (bus.Remainder),
      .DivByZero (bus.DivByZero),
      .last_iter (last_iter),
      .div_zero  (div_zero)
   );

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes reference results,
// a negedge monitor pops and compares on each rising Done.
module tb_seq_divider;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } exp_t;

   logic Clk = 1'b0;
   logic Reset = 1'b1;

   seq_divider_if #(.WIDTH(W)) bus ();

   seq_divider #(.WIDTH(W)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   pushed = 0;
   int   popped = 0;
   logic done_d = 1'b0;

   task automatic check(input bit ok, input string name,
                        input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   function automatic exp_t model(input int a, input int b);
      exp_t e;
      if (b == 0) begin
         e.q  = W'((1 << W) - 1);
         e.r  = W'(a);
         e.dz = 1'b1;
      end else begin
         e.q  = W'(a / b);
         e.r  = W'(a % b);
         e.dz = 1'b0;
      end
      return e;
   endfunction

   // Monitor: one pop per rising Done.
   always @(negedge Clk) begin
      if (!Reset && bus.Done && !done_d) begin
         if (sb.size() == 0) begin
            check(1'b0, "unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            popped++;
            check(bus.Quotient == e.q, "quotient", bus.Quotient, e.q);
            check(bus.Remainder == e.r, "remainder", bus.Remainder, e.r);
            check(bus.DivByZero == e.dz, "divbyzero", bus.DivByZero, e.dz);
         end
      end
      done_d = bus.Done;
   end

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit scramble, input int hold);
      int   lat;
      int   busy_n;
      int   exp_lat;
      int   exp_busy;
      exp_t e;
      e        = model(int'(a), int'(b));
      exp_lat  = (b == 0) ? 2 : W + 2;
      exp_busy = (b == 0) ? 1 : W + 1;
      @(negedge Clk);
      bus.Dividend = a;
      bus.Divisor  = b;
      bus.Run      = 1'b1;
      sb.push_back(e);
      pushed++;
      lat    = 0;
      busy_n = 0;
      do begin
         @(posedge Clk);
         #1;
         lat++;
         if (bus.Busy) busy_n++;
         if (scramble && lat >= 2) begin
            bus.Dividend = W'($urandom);
            bus.Divisor  = W'($urandom);
         end
      end while (!bus.Done && lat < 40);
      check(bus.Done == 1'b1, "done_timeout", lat, exp_lat);
      check(lat == exp_lat, "latency", lat, exp_lat);
      check(busy_n == exp_busy, "busy_cycles", busy_n, exp_busy);
      repeat (hold) begin
         @(posedge Clk);
         #1;
         check(bus.Done && bus.Quotient == e.q && bus.Remainder == e.r,
               "hold_finish", bus.Quotient, e.q);
      end
      bus.Run = 1'b0;
      @(posedge Clk);
      #1;
      check(!bus.Done && !bus.Busy, "back_to_idle",
            {bus.Busy, bus.Done}, 0);
   endtask

   initial begin
      bus.Run      = 1'b0;
      bus.Dividend = '0;
      bus.Divisor  = '0;
      repeat (3) @(posedge Clk);
      #1;
      check(bus.Quotient == 0 && bus.Remainder == 0 && !bus.DivByZero,
            "reset_results", bus.Quotient, 0);
      check(!bus.Busy && !bus.Done, "reset_flags", {bus.Busy, bus.Done}, 0);
      Reset = 1'b0;

      run_op(8'd100, 8'd7, 1'b0, 0);
      run_op(8'd255, 8'd1, 1'b0, 0);
      run_op(8'd255, 8'd255, 1'b0, 0);
      run_op(8'd5, 8'd9, 1'b0, 0);
      run_op(8'd0, 8'd3, 1'b0, 0);
      run_op(8'd42, 8'd0, 1'b0, 0);
      run_op(8'd100, 8'd7, 1'b0, 20);
      run_op(8'd200, 8'd13, 1'b0, 0);

      // Abort in the 4th Iter cycle: nothing pushed, results cleared.
      @(negedge Clk);
      bus.Dividend = 8'd123;
      bus.Divisor  = 8'd5;
      bus.Run      = 1'b1;
      repeat (5) @(posedge Clk);
      #1;
      check(bus.Busy == 1'b1, "abort_busy", bus.Busy, 1);
      Reset = 1'b1;
      @(posedge Clk);
      #1;
      check(bus.Quotient == 0 && bus.Remainder == 0 && !bus.DivByZero,
            "abort_results", bus.Quotient, 0);
      check(!bus.Busy && !bus.Done, "abort_flags", {bus.Busy, bus.Done}, 0);
      Reset   = 1'b0;
      bus.Run = 1'b0;
      @(posedge Clk);
      #1;

      run_op(8'd77, 8'd7, 1'b0, 0);
      run_op(8'd250, 8'd16, 1'b1, 0);

      for (int i = 0; i < 30; i++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         a = W'($urandom);
         b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         run_op(a, b, ($urandom_range(0, 1) == 1), $urandom_range(0, 2));
      end

      repeat (3) @(posedge Clk);
      #1;
      check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
      check(popped == pushed, "pop_count", popped, pushed);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Unsigned WIDTH-bit sequential restoring divider. It is the inverse-operation companion to the shift-add multiplier.
- It uses the same Run/Reset switch-driven handshake as the multiplier and sits beside it on the board top level, sharing the switch inputs and the hex-display outputs.
- One quotient bit is produced per clock through shift-and-conditional-subtract. A separate Moore FSM sequences the operation.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  level start request; sampled only in Idle and Finish.
- Dividend  in  WIDTH  numerator; captured in Load.
- Divisor  in  WIDTH  denominator; captured in Load.
- Quotient  out  WIDTH  registered result.
- Remainder  out  WIDTH  registered result.
- Busy  out  1  high in Load and Iter.
- Done  out  1  high in Finish.
- DivByZero  out  1  registered flag; valid while Done.

Behaviour:
- Reset: synchronous, active-high, overrides every state.
  - FSM goes to Idle.
  - Quotient, Remainder, DivByZero, internal A/Q/B registers and count all clear to 0.
  - Busy = Done = 0.
- Reset mid-operation aborts the operation with no partial result published.
- Internal registers:
  - A: WIDTH+1 bits, partial remainder.
  - Q: WIDTH bits, dividend shifting into the quotient.
  - B: WIDTH bits, divisor.
  - count: $clog2(WIDTH) bits.
- FSM states: Idle, Load, Iter, Finish. Moore outputs decoded from the state register only.
- Idle:
  - Run=1 → Load; otherwise stay.
  - Outputs retain the last result.
- Load (1 cycle): A←0, Q←Dividend, B←Divisor, count←0.
  - If Divisor==0 → Finish, also setting Quotient←all ones, Remainder←Dividend, DivByZero←1.
  - Otherwise → Iter.
- Iter (exactly WIDTH cycles), each cycle:
  - {A',Q'} = {A,Q} << 1.
  - diff = A' − {0,B}, computed at WIDTH+2 bits so the sign is visible.
  - If diff ≥ 0: A←diff, Q←{Q'[WIDTH-1:1],1}.
  - Else: A←A', Q←{Q'[WIDTH-1:1],0}.
  - count←count+1.
  - On the cycle where count==WIDTH−1 → Finish, loading Quotient←final Q and Remainder←final A[WIDTH-1:0], DivByZero←0.
  - The final Q and A are the values being written that cycle, not the old register contents.
- Finish:
  - Run=1 → stay; no auto-restart while the switch is held.
  - Run=0 → Idle.
- Quotient/Remainder change only on entry to Finish or on Reset. Intermediate values are never visible.
- Latency, counting from the edge that samples Run=1 in Idle:
  - Normal division: Done high after 2+WIDTH−1+1 = WIDTH+2 edges (10 for WIDTH=8).
  - Divide-by-zero: Done high after 2 edges.
- Run toggling during Load/Iter is ignored.
- Dividend/Divisor changes after Load are ignored.
- Back-to-back operation: Run must drop (Finish→Idle) and rise again. The minimum gap is one Idle cycle.
- The A register never exceeds 2·B−1, so WIDTH+1 bits suffice. The subtract carry-out is the sole restore decision.

Decomposition:
- Package div_pkg:
  - state enum (Idle, Load, Iter, Finish) as logic [1:0].
  - Default WIDTH constant.
- One natural sub-module, div_datapath: A/Q/B/count registers, the shift-subtract step, and the output result registers.
  - Controlled by load, step, and publish strobes from the FSM in seq_divider.
  - Returns last_iter and div_zero status.

Test Plan:
- Reset, then Dividend=100, Divisor=7, Run pulse → Busy for 9 cycles; Done 10 edges after the Run sample; Quotient=14, Remainder=2, DivByZero=0.
- Boundary operand pairs, each → Done at 10 edges:
  - 255/1 → Q=255, R=0.
  - 255/255 → Q=1, R=0.
  - 5/9 → Q=0, R=5.
  - 0/3 → Q=0, R=0.
- 42/0 → Done 2 edges after the Run sample; Quotient=8'hFF, Remainder=42, DivByZero=1.
- Run held high through Finish for 20 cycles → stays Finish, outputs stable. Run low → Idle next edge. Run high with 200/13 → Q=15, R=5.
- Reset asserted during the 4th Iter cycle → next edge Idle; Quotient=Remainder=0; Busy=Done=0. A subsequent 77/7 completes correctly (Q=11, R=0).
- Dividend/Divisor changed every cycle during Iter after loading 250/16 → result Q=15, R=10, unaffected by the changes.
